// File: rtl/axi_tlb_rd_xlat.sv
// AR-side translation sequencer: one AR at a time is looked up in the L1 table,
// then forwarded with the translated address on a hit or answered locally with DECERR beats on a miss.
module axi_tlb_rd_xlat #(
    parameter int AddrWidthIn  = 32,
    parameter int AddrWidthOut = 32,
    parameter int IdWidth      = 4,
    parameter int LenWidth     = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AddrWidthIn-1:0]  slv_ar_addr_i,
    input  logic [IdWidth-1:0]      slv_ar_id_i,
    input  logic [LenWidth-1:0]     slv_ar_len_i,
    input  logic                    slv_ar_valid_i,
    output logic                    slv_ar_ready_o,
    output logic [AddrWidthIn-1:0]  tlb_req_addr_o,
    output logic                    tlb_req_valid_o,
    input  logic                    tlb_req_ready_i,
    input  logic                    tlb_res_hit_i,
    input  logic [AddrWidthOut-1:0] tlb_res_addr_i,
    input  logic                    tlb_res_valid_i,
    output logic                    tlb_res_ready_o,
    output logic [AddrWidthOut-1:0] mst_ar_addr_o,
    output logic [IdWidth-1:0]      mst_ar_id_o,
    output logic [LenWidth-1:0]     mst_ar_len_o,
    output logic                    mst_ar_valid_o,
    input  logic                    mst_ar_ready_i,
    output logic [IdWidth-1:0]      err_r_id_o,
    output logic [1:0]              err_r_resp_o,
    output logic                    err_r_last_o,
    output logic                    err_r_valid_o,
    input  logic                    err_r_ready_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XLAT = 3'd1,
        RES  = 3'd2,
        FWD  = 3'd3,
        ERR  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrWidthIn-1:0]  addr_q, addr_d;
    logic [IdWidth-1:0]      id_q, id_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic [AddrWidthOut-1:0] xaddr_q, xaddr_d;
    logic [LenWidth-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            xaddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            xaddr_q <= xaddr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        id_d            = id_q;
        len_d           = len_q;
        xaddr_d         = xaddr_q;
        cnt_d           = cnt_q;
        slv_ar_ready_o  = 1'b0;
        tlb_req_valid_o = 1'b0;
        tlb_res_ready_o = 1'b0;
        mst_ar_valid_o  = 1'b0;
        err_r_valid_o   = 1'b0;

        case (state_q)
            IDLE: begin
                slv_ar_ready_o = 1'b1;
                if (slv_ar_valid_i) begin
                    addr_d  = slv_ar_addr_i;
                    id_d    = slv_ar_id_i;
                    len_d   = slv_ar_len_i;
                    state_d = XLAT;
                end
            end
            XLAT: begin
                tlb_req_valid_o = 1'b1;
                tlb_res_ready_o = 1'b1;
                // A fall-through table may answer in the request cycle; resolve without visiting RES.
                if (tlb_req_ready_i) begin
                    if (tlb_res_valid_i) begin
                        if (tlb_res_hit_i) begin
                            xaddr_d = tlb_res_addr_i;
                            state_d = FWD;
                        end else begin
                            cnt_d   = len_q;
                            state_d = ERR;
                        end
                    end else begin
                        state_d = RES;
                    end
                end
            end
            RES: begin
                tlb_res_ready_o = 1'b1;
                if (tlb_res_valid_i) begin
                    if (tlb_res_hit_i) begin
                        xaddr_d = tlb_res_addr_i;
                        state_d = FWD;
                    end else begin
                        cnt_d   = len_q;
                        state_d = ERR;
                    end
                end
            end
            FWD: begin
                mst_ar_valid_o = 1'b1;
                if (mst_ar_ready_i) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                err_r_valid_o = 1'b1;
                // cnt_q counts remaining beats after this one, so it stops at zero and never wraps.
                if (err_r_ready_i) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tlb_req_addr_o = addr_q;
    assign mst_ar_addr_o  = xaddr_q;
    assign mst_ar_id_o    = id_q;
    assign mst_ar_len_o   = len_q;
    assign err_r_id_o     = id_q;
    assign err_r_resp_o   = 2'b11;
    assign err_r_last_o   = (state_q == ERR) && (cnt_q == '0);

endmodule

// File: tb/tb_axi_tlb_rd_xlat.sv
// Directed bench for axi_tlb_rd_xlat: hit, delayed result, miss bursts, backpressure and reset mid-burst.
module tb_axi_tlb_rd_xlat;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] slv_ar_addr_i = '0;
    logic [3:0]  slv_ar_id_i = '0;
    logic [7:0]  slv_ar_len_i = '0;
    logic        slv_ar_valid_i = 1'b0;
    logic        slv_ar_ready_o;
    logic [31:0] tlb_req_addr_o;
    logic        tlb_req_valid_o;
    logic        tlb_req_ready_i = 1'b0;
    logic        tlb_res_hit_i = 1'b0;
    logic [31:0] tlb_res_addr_i = '0;
    logic        tlb_res_valid_i = 1'b0;
    logic        tlb_res_ready_o;
    logic [31:0] mst_ar_addr_o;
    logic [3:0]  mst_ar_id_o;
    logic [7:0]  mst_ar_len_o;
    logic        mst_ar_valid_o;
    logic        mst_ar_ready_i = 1'b0;
    logic [3:0]  err_r_id_o;
    logic [1:0]  err_r_resp_o;
    logic        err_r_last_o;
    logic        err_r_valid_o;
    logic        err_r_ready_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int beats = 0;
    int last_beats = 0;
    int last_idx = 0;
    int mst_hs = 0;

    axi_tlb_rd_xlat dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_id_i(slv_ar_id_i),
        .slv_ar_len_i(slv_ar_len_i), .slv_ar_valid_i(slv_ar_valid_i),
        .slv_ar_ready_o(slv_ar_ready_o),
        .tlb_req_addr_o(tlb_req_addr_o), .tlb_req_valid_o(tlb_req_valid_o),
        .tlb_req_ready_i(tlb_req_ready_i),
        .tlb_res_hit_i(tlb_res_hit_i), .tlb_res_addr_i(tlb_res_addr_i),
        .tlb_res_valid_i(tlb_res_valid_i), .tlb_res_ready_o(tlb_res_ready_o),
        .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_id_o(mst_ar_id_o),
        .mst_ar_len_o(mst_ar_len_o), .mst_ar_valid_o(mst_ar_valid_o),
        .mst_ar_ready_i(mst_ar_ready_i),
        .err_r_id_o(err_r_id_o), .err_r_resp_o(err_r_resp_o),
        .err_r_last_o(err_r_last_o), .err_r_valid_o(err_r_valid_o),
        .err_r_ready_i(err_r_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Beat/handshake monitor plus the protocol rule that a result never arrives without its request.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (err_r_valid_o && err_r_ready_i) begin
                beats = beats + 1;
                if (err_r_last_o) begin
                    last_beats = last_beats + 1;
                    last_idx = beats;
                end
            end
            if (mst_ar_valid_o && mst_ar_ready_i) mst_hs = mst_hs + 1;
            assert (!(tlb_req_valid_o && tlb_res_valid_i && !tlb_req_ready_i)) else begin
                failures = failures + 1;
                $error("FAIL res_without_req observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_slv_rdy"}, slv_ar_ready_o, 1);
        chk({tag, "_req_vld"}, tlb_req_valid_o, 0);
        chk({tag, "_res_rdy"}, tlb_res_ready_o, 0);
        chk({tag, "_mst_vld"}, mst_ar_valid_o, 0);
        chk({tag, "_err_vld"}, err_r_valid_o, 0);
    endtask

    initial begin
        int base, base_last, base_hs, n;

        // Reset state
        #1;
        idle_outs("rst");
        chk("rst_req_addr", tlb_req_addr_o, 0);
        chk("rst_mst_addr", mst_ar_addr_o, 0);
        chk("rst_mst_id", mst_ar_id_o, 0);
        chk("rst_mst_len", mst_ar_len_o, 0);
        chk("rst_err_id", err_r_id_o, 0);
        chk("rst_err_last", err_r_last_o, 0);
        chk("rst_err_resp", err_r_resp_o, 2'b11);
        step(); step();
        rst_ni = 1'b1;
        step();

        // Hit with zero-wait fall-through table
        slv_ar_addr_i = 32'h0000_3010; slv_ar_id_i = 4'd5; slv_ar_len_i = 8'd3; slv_ar_valid_i = 1'b1;
        tlb_req_ready_i = 1'b1; tlb_res_valid_i = 1'b1; tlb_res_hit_i = 1'b1;
        tlb_res_addr_i = 32'h8000_1010; mst_ar_ready_i = 1'b1;
        step();
        slv_ar_valid_i = 1'b0;
        chk("hit_req_vld", tlb_req_valid_o, 1);
        chk("hit_req_addr", tlb_req_addr_o, 32'h0000_3010);
        chk("hit_res_rdy", tlb_res_ready_o, 1);
        chk("hit_slv_rdy_busy", slv_ar_ready_o, 0);
        step();
        chk("hit_mst_vld", mst_ar_valid_o, 1);
        chk("hit_mst_addr", mst_ar_addr_o, 32'h8000_1010);
        chk("hit_mst_id", mst_ar_id_o, 5);
        chk("hit_mst_len", mst_ar_len_o, 3);
        chk("hit_req_vld_off", tlb_req_valid_o, 0);
        step();
        idle_outs("hit_done");
        tlb_res_valid_i = 1'b0;

        // Delayed result, with one request stall first
        slv_ar_addr_i = 32'h0000_1000; slv_ar_id_i = 4'd2; slv_ar_len_i = 8'd0; slv_ar_valid_i = 1'b1;
        tlb_req_ready_i = 1'b0; mst_ar_ready_i = 1'b0;
        step();
        slv_ar_valid_i = 1'b0;
        chk("dly_req_vld", tlb_req_valid_o, 1);
        step();
        chk("dly_req_hold", tlb_req_valid_o, 1);
        chk("dly_req_addr_hold", tlb_req_addr_o, 32'h0000_1000);
        tlb_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dly_res_req_vld", tlb_req_valid_o, 0);
            chk("dly_res_rdy", tlb_res_ready_o, 1);
            chk("dly_res_mst_vld", mst_ar_valid_o, 0);
        end
        tlb_res_valid_i = 1'b1; tlb_res_hit_i = 1'b1; tlb_res_addr_i = 32'hA000_1000;
        step();
        tlb_res_valid_i = 1'b0;
        chk("dly_mst_vld", mst_ar_valid_o, 1);
        chk("dly_mst_addr", mst_ar_addr_o, 32'hA000_1000);
        chk("dly_mst_len", mst_ar_len_o, 0);
        mst_ar_ready_i = 1'b1;
        step();
        idle_outs("dly_done");

        // Miss burst, len=2, ready pattern 1,0,1,1
        base = beats; base_last = last_beats; base_hs = mst_hs;
        slv_ar_addr_i = 32'h0000_2000; slv_ar_id_i = 4'd9; slv_ar_len_i = 8'd2; slv_ar_valid_i = 1'b1;
        tlb_res_valid_i = 1'b1; tlb_res_hit_i = 1'b0; err_r_ready_i = 1'b1;
        step();
        slv_ar_valid_i = 1'b0;
        step();
        tlb_res_valid_i = 1'b0;
        chk("miss_err_vld", err_r_valid_o, 1);
        chk("miss_err_id", err_r_id_o, 9);
        chk("miss_err_resp", err_r_resp_o, 2'b11);
        chk("miss_last_b1", err_r_last_o, 0);
        chk("miss_mst_vld", mst_ar_valid_o, 0);
        step();
        chk("miss_last_b2", err_r_last_o, 0);
        err_r_ready_i = 1'b0;
        step();
        chk("miss_stall_vld", err_r_valid_o, 1);
        chk("miss_stall_last", err_r_last_o, 0);
        err_r_ready_i = 1'b1;
        step();
        chk("miss_last_b3", err_r_last_o, 1);
        chk("miss_err_id_b3", err_r_id_o, 9);
        step();
        idle_outs("miss_done");
        chk("miss_beats", beats - base, 3);
        chk("miss_last_cnt", last_beats - base_last, 1);
        chk("miss_last_idx", last_idx - base, 3);
        chk("miss_no_mst", mst_hs - base_hs, 0);

        // Downstream backpressure with a waiting AR
        slv_ar_addr_i = 32'h0000_4000; slv_ar_id_i = 4'd3; slv_ar_len_i = 8'd7; slv_ar_valid_i = 1'b1;
        tlb_res_valid_i = 1'b1; tlb_res_hit_i = 1'b1; tlb_res_addr_i = 32'hC000_4000;
        mst_ar_ready_i = 1'b0;
        step();
        slv_ar_addr_i = 32'h0000_5000; slv_ar_id_i = 4'd6; slv_ar_len_i = 8'd1;
        step();
        tlb_res_addr_i = 32'hD000_5000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_mst_vld", mst_ar_valid_o, 1);
            chk("bp_mst_addr", mst_ar_addr_o, 32'hC000_4000);
            chk("bp_mst_id", mst_ar_id_o, 3);
            chk("bp_mst_len", mst_ar_len_o, 7);
            chk("bp_slv_rdy", slv_ar_ready_o, 0);
            step();
        end
        mst_ar_ready_i = 1'b1;
        step();
        chk("bp_idle_slv_rdy", slv_ar_ready_o, 1);
        chk("bp_idle_req_vld", tlb_req_valid_o, 0);
        chk("bp_idle_mst_vld", mst_ar_valid_o, 0);
        step();
        slv_ar_valid_i = 1'b0;
        chk("bp_next_req_vld", tlb_req_valid_o, 1);
        chk("bp_next_req_addr", tlb_req_addr_o, 32'h0000_5000);
        step();
        chk("bp_next_mst_addr", mst_ar_addr_o, 32'hD000_5000);
        chk("bp_next_mst_id", mst_ar_id_o, 6);
        chk("bp_next_mst_len", mst_ar_len_o, 1);
        step();
        idle_outs("bp_done");

        // Maximum-length miss: 256 beats
        base = beats; base_last = last_beats;
        slv_ar_addr_i = 32'h0000_6000; slv_ar_id_i = 4'd1; slv_ar_len_i = 8'd255; slv_ar_valid_i = 1'b1;
        tlb_res_hit_i = 1'b0; err_r_ready_i = 1'b1;
        step();
        slv_ar_valid_i = 1'b0;
        step();
        tlb_res_valid_i = 1'b0;
        n = 0;
        while (err_r_valid_o && n < 400) begin
            step();
            n++;
        end
        chk("max_bounded", (n < 400) ? 1 : 0, 1);
        chk("max_beats", beats - base, 256);
        chk("max_last_cnt", last_beats - base_last, 1);
        chk("max_last_idx", last_idx - base, 256);
        idle_outs("max_done");

        // Reset in the middle of a 20-beat error burst
        base = beats;
        slv_ar_addr_i = 32'h0000_7000; slv_ar_id_i = 4'd4; slv_ar_len_i = 8'd19; slv_ar_valid_i = 1'b1;
        tlb_res_valid_i = 1'b1; tlb_res_hit_i = 1'b0;
        step();
        slv_ar_valid_i = 1'b0;
        step();
        tlb_res_valid_i = 1'b0;
        n = 0;
        while ((beats - base) < 10 && n < 100) begin
            step();
            n++;
        end
        chk("rstm_ten_beats", beats - base, 10);
        chk("rstm_in_err", err_r_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        idle_outs("rstm_async");
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            idle_outs("rstm_after");
        end
        chk("rstm_no_more_beats", beats - base, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
